// File: rtl/pcpi_issue_ctrl.sv
// rtl/pcpi_issue_ctrl.sv - PCPI master-side issue controller with no-response timeout trap
// Optional macro PCPI_ISSUE_PERF_EN adds perf_busy/perf_traps counters.
module pcpi_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi_wr,
  input  logic [31:0] pcpi_rd,
  input  logic        pcpi_wait,
  input  logic        pcpi_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_wr,
  output logic [31:0] rsp_rd,
  output logic        rsp_trap
`ifdef PCPI_ISSUE_PERF_EN
  ,
  output logic [31:0] perf_busy,
  output logic [15:0] perf_traps
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              pcpi_valid_nxt, rsp_valid_nxt, rsp_wr_nxt, rsp_trap_nxt;
  logic [31:0]       pcpi_insn_nxt, pcpi_rs1_nxt, pcpi_rs2_nxt, rsp_rd_nxt;
  logic              trap_evt;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      rsp_valid  <= 1'b0;
      rsp_wr     <= 1'b0;
      rsp_rd     <= '0;
      rsp_trap   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pcpi_valid <= pcpi_valid_nxt;
      pcpi_insn  <= pcpi_insn_nxt;
      pcpi_rs1   <= pcpi_rs1_nxt;
      pcpi_rs2   <= pcpi_rs2_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_wr     <= rsp_wr_nxt;
      rsp_rd     <= rsp_rd_nxt;
      rsp_trap   <= rsp_trap_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    pcpi_valid_nxt = pcpi_valid;
    pcpi_insn_nxt  = pcpi_insn;
    pcpi_rs1_nxt   = pcpi_rs1;
    pcpi_rs2_nxt   = pcpi_rs2;
    rsp_valid_nxt  = rsp_valid;
    rsp_wr_nxt     = rsp_wr;
    rsp_rd_nxt     = rsp_rd;
    rsp_trap_nxt   = rsp_trap;
    trap_evt       = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          pcpi_insn_nxt  = req_insn;
          pcpi_rs1_nxt   = req_rs1;
          pcpi_rs2_nxt   = req_rs2;
          pcpi_valid_nxt = 1'b1;
          cnt_nxt        = '0;
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        // A slave completing in the timeout cycle still wins over the trap.
        if (pcpi_ready) begin
          rsp_wr_nxt     = pcpi_wr;
          rsp_rd_nxt     = pcpi_rd;
          rsp_trap_nxt   = 1'b0;
          pcpi_valid_nxt = 1'b0;
          rsp_valid_nxt  = 1'b1;
          state_nxt      = RESP;
        end else if (pcpi_wait) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          rsp_trap_nxt   = 1'b1;
          rsp_wr_nxt     = 1'b0;
          rsp_rd_nxt     = '0;
          pcpi_valid_nxt = 1'b0;
          rsp_valid_nxt  = 1'b1;
          trap_evt       = 1'b1;
          state_nxt      = RESP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef PCPI_ISSUE_PERF_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      perf_busy  <= '0;
      perf_traps <= '0;
    end else begin
      if (state == ISSUE) perf_busy <= perf_busy + 1'b1;
      if (trap_evt) perf_traps <= perf_traps + 1'b1;
    end
  end
`endif

endmodule

// File: doc/pcpi_issue_ctrl.md
Name: pcpi_issue_ctrl

Overview:
PCPI master-side issue controller. It sits directly upstream of the fast multiplier coprocessor and any other PCPI slave on the same bus.
- Accepts one instruction request at a time from the core's execute stage.
- Drives pcpi_valid, pcpi_insn, pcpi_rs1 and pcpi_rs2 until the slave signals pcpi_ready.
- Enforces a no-response timeout and returns the result or a trap to the core through a valid/ready response port.

Parameters:
- TIMEOUT_CYCLES, 16: ISSUE cycles without pcpi_ready (and without pcpi_wait) before a trap is raised; legal range 2..255.
- CNT_W, 8: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  Single clock; all logic updates on the rising edge.
- resetn  input  1  Synchronous reset, active-low. The reset is sampled only on the rising edge of clk.
- req_valid  input  1  Core presents an instruction.
- req_ready  output  1  Controller can accept a request.
- req_insn  input  32  Instruction word.
- req_rs1  input  32  Operand 1.
- req_rs2  input  32  Operand 2.
- pcpi_valid  output  1  Request to the PCPI slave, registered.
- pcpi_insn  output  32  Latched instruction word.
- pcpi_rs1  output  32  Latched operand 1.
- pcpi_rs2  output  32  Latched operand 2.
- pcpi_wr  input  1  Slave writes rd.
- pcpi_rd  input  32  Slave result.
- pcpi_wait  input  1  Slave requests timeout extension.
- pcpi_ready  input  1  Slave completes.
- rsp_valid  output  1  Response available.
- rsp_ready  input  1  Core consumes the response.
- rsp_wr  output  1  Captured pcpi_wr.
- rsp_rd  output  32  Captured pcpi_rd.
- rsp_trap  output  1  Timeout occurred (illegal instruction).

Behaviour:
- Reset, synchronous, applied when resetn=0 at a rising edge:
  - State goes to IDLE.
  - pcpi_valid, rsp_valid, rsp_wr and rsp_trap go to 0.
  - pcpi_insn, pcpi_rs1, pcpi_rs2 and rsp_rd go to 0.
  - The timeout counter goes to 0.
  - Reset mid-operation abandons the transaction. pcpi_valid is low from the first cycle after the reset edge, and no response is produced.
- State machine, three states: IDLE, ISSUE, RESP.
- IDLE:
  - req_ready=1 (combinational from state); in all other states req_ready=0.
  - When req_valid=1, the controller latches insn, rs1 and rs2 into the pcpi_* registers, sets pcpi_valid=1, clears the counter, and moves to ISSUE.
  - pcpi_valid therefore rises in the cycle after the request handshake.
- ISSUE:
  - pcpi_valid=1 and the pcpi_* signals are held stable.
  - pcpi_ready=1: capture pcpi_wr into rsp_wr and pcpi_rd into rsp_rd, set rsp_trap=0, pcpi_valid<=0, rsp_valid<=1, and move to RESP. Because pcpi_valid drops on the edge after pcpi_ready, no slave ever sees a second launch.
  - Otherwise, pcpi_wait=1: counter<=0 (the timeout is extended).
  - Otherwise, counter==TIMEOUT_CYCLES-1: rsp_trap<=1, rsp_wr<=0, rsp_rd<=0, pcpi_valid<=0, rsp_valid<=1, and move to RESP.
  - Otherwise: counter<=counter+1.
  - Priority when events coincide: pcpi_ready > pcpi_wait > timeout. If ready arrives in the timeout cycle, the response is a normal (non-trap) result.
- RESP:
  - rsp_valid=1 and rsp_* are held stable until rsp_ready=1. On rsp_ready=1: rsp_valid<=0 and move to IDLE.
  - A new request is accepted in the cycle after RESP exits; there is no same-cycle turnaround.
- Latency with the fast multiplier (ready two cycles after pcpi_valid rises): request handshake at cycle T, pcpi_valid at T+1, pcpi_ready at T+3, rsp_valid at T+4.
- pcpi_* inputs are ignored outside ISSUE.
- rsp_rd is a full 32-bit copy; no sign or width manipulation is done.

Optional Feature:
- Macro: PCPI_ISSUE_PERF_EN.
- With the macro defined:
  - Extra output ports perf_busy (32 bits) and perf_traps (16 bits).
  - perf_busy increments on every cycle in the ISSUE state.
  - perf_traps increments on every timeout trap.
  - Both counters wrap on overflow and are cleared by reset.
- Without the macro, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- MUL with the fast multiplier attached: req insn=0x02B50533, rs1=7, rs2=6 at T -> pcpi_valid high T+1..T+3, rsp_valid at T+4 with rsp_rd=42, rsp_wr=1, rsp_trap=0.
- Non-M instruction (insn=0x00B50533, no slave responds) -> exactly 16 ISSUE cycles, then rsp_valid=1, rsp_trap=1, rsp_rd=0, rsp_wr=0.
- pcpi_wait pulsed on the 10th ISSUE cycle with ready never asserted -> trap occurs 16 cycles after the pulse, 26 ISSUE cycles total.
- pcpi_ready coincident with counter==15 -> normal response, rsp_trap=0.
- MULHU of rs1=0xFFFFFFFF by rs2=0xFFFFFFFF with rsp_ready held low for 5 cycles -> rsp_rd=0xFFFFFFFE held stable, req_ready=0 throughout, and IDLE entered the cycle after rsp_ready=1.
- resetn low for one cycle during ISSUE -> pcpi_valid=0 and rsp_valid=0 the next cycle, state IDLE, and a subsequent MUL of 3*5 returns rsp_rd=15. With PCPI_ISSUE_PERF_EN defined, perf_busy resets to 0.
